// File: rtl/hough_frame_ctrl.sv
// Frame sequencer for the lane-detection pipeline: admits exactly one frame per Hough pass,
// latches lane results, counts frames and flushes the pipeline if the Hough stage stalls.
module hough_frame_ctrl #(
   parameter int WIDTH          = 512,
   parameter int HEIGHT         = 288,
   parameter int RHO_BITS       = 11,
   parameter int THETA_BITS     = 9,
   parameter int TIMEOUT_CYCLES = 4000000,
   parameter int FLUSH_CYCLES   = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         run_i,
   input  logic                         clear_err_i,
   input  logic                         src_wr_en_i,
   output logic                         src_full_o,
   output logic                         pipe_wr_en_o,
   input  logic                         pipe_full_i,
   input  logic                         hough_done_i,
   input  logic signed [RHO_BITS-1:0]   left_rho_i,
   input  logic signed [RHO_BITS-1:0]   right_rho_i,
   input  logic        [THETA_BITS-1:0] left_theta_i,
   input  logic        [THETA_BITS-1:0] right_theta_i,
   output logic signed [RHO_BITS-1:0]   left_rho_o,
   output logic signed [RHO_BITS-1:0]   right_rho_o,
   output logic        [THETA_BITS-1:0] left_theta_o,
   output logic        [THETA_BITS-1:0] right_theta_o,
   output logic                         result_valid_o,
   output logic                         frame_active_o,
   output logic        [15:0]           frame_count_o,
   output logic                         timeout_err_o,
   output logic                         pipe_flush_o
);

   localparam int NPIX  = WIDTH * HEIGHT;
   localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
   localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
   localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYCLES - 1);
   localparam logic [FL_W-1:0]  FL_ONE   = FL_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_FLUSH = 3'd4
   } state_e;

   state_e                     state_q, state_d;
   logic   [PIX_W-1:0]         pix_cnt_q, pix_cnt_d;
   logic   [WD_W-1:0]          wd_cnt_q, wd_cnt_d;
   logic   [FL_W-1:0]          fl_cnt_q, fl_cnt_d;
   logic                       load_q;
   logic                       frame_active_q;
   logic                       pipe_flush_q;
   logic                       result_valid_q;
   logic                       timeout_err_q;
   logic   [15:0]              frame_count_q;
   logic   [RHO_BITS-1:0]      left_rho_q, right_rho_q;
   logic   [THETA_BITS-1:0]    left_theta_q, right_theta_q;
   logic                       accept_s;
   logic                       latch_s;
   logic                       flush_set_s;

   // load_q mirrors (state_q == S_LOAD) as a flop so the handshake only sees a registered term
   assign pipe_wr_en_o = src_wr_en_i & ~pipe_full_i & load_q;
   assign src_full_o   = pipe_full_i | ~load_q;
   assign accept_s     = src_wr_en_i & pipe_wr_en_o;

   // Next-state, pixel counter, watchdog and flush-length counter
   always_comb begin
      state_d     = state_q;
      pix_cnt_d   = pix_cnt_q;
      wd_cnt_d    = wd_cnt_q;
      fl_cnt_d    = fl_cnt_q;
      latch_s     = 1'b0;
      flush_set_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            pix_cnt_d = '0;
            wd_cnt_d  = '0;
            if (run_i) state_d = S_LOAD;
            else       state_d = S_IDLE;
         end
         S_LOAD: begin
            if (!accept_s) begin
               pix_cnt_d = pix_cnt_q;
            end else if (pix_cnt_q == PIX_LAST) begin
               pix_cnt_d = '0;
               state_d   = S_WAIT;
            end else begin
               pix_cnt_d = pix_cnt_q + PIX_ONE;
            end
         end
         S_WAIT: begin
            // a done arriving on the final watchdog cycle still completes the frame
            if (hough_done_i) begin
               latch_s  = 1'b1;
               wd_cnt_d = '0;
               state_d  = S_DONE;
            end else if (wd_cnt_q == WD_LAST) begin
               flush_set_s = 1'b1;
               wd_cnt_d    = '0;
               fl_cnt_d    = '0;
               state_d     = S_FLUSH;
            end else begin
               wd_cnt_d = wd_cnt_q + WD_ONE;
            end
         end
         S_DONE: begin
            if (run_i) state_d = S_LOAD;
            else       state_d = S_IDLE;
         end
         S_FLUSH: begin
            if (fl_cnt_q == FL_LAST) begin
               fl_cnt_d = '0;
               state_d  = S_IDLE;
            end else begin
               fl_cnt_d = fl_cnt_q + FL_ONE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            pix_cnt_d = '0;
            wd_cnt_d  = '0;
            fl_cnt_d  = '0;
         end
      endcase
   end

   // FSM state and counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         pix_cnt_q <= '0;
         wd_cnt_q  <= '0;
         fl_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         pix_cnt_q <= pix_cnt_d;
         wd_cnt_q  <= wd_cnt_d;
         fl_cnt_q  <= fl_cnt_d;
      end
   end

   // Registered status outputs, result latch, frame counter and sticky watchdog error
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         load_q         <= 1'b0;
         frame_active_q <= 1'b0;
         pipe_flush_q   <= 1'b0;
         result_valid_q <= 1'b0;
         timeout_err_q  <= 1'b0;
         frame_count_q  <= 16'd0;
         left_rho_q     <= '0;
         right_rho_q    <= '0;
         left_theta_q   <= '0;
         right_theta_q  <= '0;
      end else begin
         load_q         <= (state_d == S_LOAD);
         frame_active_q <= (state_d == S_LOAD) || (state_d == S_WAIT);
         pipe_flush_q   <= (state_d == S_FLUSH);
         result_valid_q <= latch_s;
         if (latch_s) begin
            frame_count_q <= frame_count_q + 16'd1;
            left_rho_q    <= left_rho_i;
            right_rho_q   <= right_rho_i;
            left_theta_q  <= left_theta_i;
            right_theta_q <= right_theta_i;
         end else begin
            frame_count_q <= frame_count_q;
         end
         if (flush_set_s)      timeout_err_q <= 1'b1;
         else if (clear_err_i) timeout_err_q <= 1'b0;
         else                  timeout_err_q <= timeout_err_q;
      end
   end

   assign frame_active_o = frame_active_q;
   assign pipe_flush_o   = pipe_flush_q;
   assign result_valid_o = result_valid_q;
   assign timeout_err_o  = timeout_err_q;
   assign frame_count_o  = frame_count_q;
   assign left_rho_o     = left_rho_q;
   assign right_rho_o    = right_rho_q;
   assign left_theta_o   = left_theta_q;
   assign right_theta_o  = right_theta_q;

endmodule

// File: tb/tb_hough_frame_ctrl.sv
// Self-checking bench for hough_frame_ctrl: randomized stimulus compared every cycle against
// a counter-based reference model, plus targeted checks for each scenario.
module tb_hough_frame_ctrl;

   localparam int W = 4, H = 2, T = 100, F = 4, RB = 11, TB = 9;
   localparam int NP = W * H;

   logic clk = 1'b0, rst_n = 1'b0;
   logic run = 1'b0, clear_err = 1'b0, src_wr = 1'b0, pipe_full = 1'b0, hough_done = 1'b0;
   logic signed [RB-1:0] lrho_i = '0, rrho_i = '0;
   logic        [TB-1:0] lth_i = '0, rth_i = '0;
   logic src_full_o, pipe_wr_en_o, result_valid_o, frame_active_o, timeout_err_o, pipe_flush_o;
   logic signed [RB-1:0] lrho_o, rrho_o;
   logic        [TB-1:0] lth_o, rth_o;
   logic        [15:0]   frame_count_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   hough_frame_ctrl #(
      .WIDTH(W), .HEIGHT(H), .RHO_BITS(RB), .THETA_BITS(TB),
      .TIMEOUT_CYCLES(T), .FLUSH_CYCLES(F)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .run_i(run), .clear_err_i(clear_err),
      .src_wr_en_i(src_wr), .src_full_o(src_full_o), .pipe_wr_en_o(pipe_wr_en_o),
      .pipe_full_i(pipe_full), .hough_done_i(hough_done),
      .left_rho_i(lrho_i), .right_rho_i(rrho_i), .left_theta_i(lth_i), .right_theta_i(rth_i),
      .left_rho_o(lrho_o), .right_rho_o(rrho_o), .left_theta_o(lth_o), .right_theta_o(rth_o),
      .result_valid_o(result_valid_o), .frame_active_o(frame_active_o),
      .frame_count_o(frame_count_o), .timeout_err_o(timeout_err_o), .pipe_flush_o(pipe_flush_o)
   );

   // Reference model: pixels taken this frame, cycles spent waiting, flush cycles remaining
   bit          m_loading, m_done, m_err;
   int          m_pix, m_wait, m_flush;
   logic [15:0] m_fc;
   logic [RB-1:0] m_lrho, m_rrho;
   logic [TB-1:0] m_lth, m_rth;

   function automatic void model_reset();
      m_loading = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_pix = 0; m_wait = -1; m_flush = 0; m_fc = 16'd0;
      m_lrho = '0; m_rrho = '0; m_lth = '0; m_rth = '0;
   endfunction

   function automatic void model_step();
      bit timed_out;
      timed_out = 1'b0;
      if (!rst_n) return;
      if (m_done) begin
         m_done = 1'b0;
         if (run) begin m_loading = 1'b1; m_pix = 0; end
      end else if (m_flush > 0) begin
         m_flush = m_flush - 1;
      end else if (m_wait >= 0) begin
         if (hough_done) begin
            m_lrho = lrho_i; m_rrho = rrho_i; m_lth = lth_i; m_rth = rth_i;
            m_fc = m_fc + 16'd1; m_done = 1'b1; m_wait = -1;
         end else if (m_wait == T - 1) begin
            m_wait = -1; m_flush = F; timed_out = 1'b1;
         end else begin
            m_wait = m_wait + 1;
         end
      end else if (m_loading) begin
         if (src_wr && !pipe_full) begin
            m_pix = m_pix + 1;
            if (m_pix == NP) begin m_loading = 1'b0; m_wait = 0; end
         end
      end else if (run) begin
         m_loading = 1'b1; m_pix = 0;
      end
      if (timed_out) m_err = 1'b1;
      else if (clear_err) m_err = 1'b0;
   endfunction

   function automatic logic [61:0] exp_vec();
      return {pipe_full | ~m_loading, src_wr & ~pipe_full & m_loading, (m_flush > 0), m_done,
              m_loading | (m_wait >= 0), m_err, m_fc, m_lrho, m_rrho, m_lth, m_rth};
   endfunction

   function automatic logic [61:0] dut_vec();
      return {src_full_o, pipe_wr_en_o, pipe_flush_o, result_valid_o, frame_active_o,
              timeout_err_o, frame_count_o, lrho_o, rrho_o, lth_o, rth_o};
   endfunction

   task automatic step();
      model_step();
      @(negedge clk);
   endtask

   task automatic rand_results();
      lrho_i = RB'($urandom); rrho_i = RB'($urandom);
      lth_i  = TB'($urandom); rth_i  = TB'($urandom);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; run = 1'b0; clear_err = 1'b0; src_wr = 1'b0; pipe_full = 1'b0;
      hough_done = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      rst_n = 1'b0; run = 1'b1; src_wr = 1'b1;
      #1;
      tests++;
      if (dut_vec() !== exp_vec()) begin
         fails++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), exp_vec());
      end
      tests++;
      if (src_full_o !== 1'b1 || pipe_wr_en_o !== 1'b0 || frame_count_o !== 16'd0) begin
         fails++; $display("FAIL reset_handshake src_full=%b pipe_wr=%b fc=%0d exp 1 0 0",
                           src_full_o, pipe_wr_en_o, frame_count_o);
      end
      step();
      rst_n = 1'b1;
      #1;
      tests++;
      if (src_full_o !== 1'b1) begin
         fails++; $display("FAIL idle_first_cycle src_full=%b exp 1", src_full_o);
      end
      step();
      #1;
      tests++;
      if (src_full_o !== 1'b0 || dut_vec() !== exp_vec()) begin
         fails++; $display("FAIL idle_to_load got=%h exp=%h", dut_vec(), exp_vec());
      end
      step();
   endtask

   task automatic test_basic();
      int acc, c, d;
      logic signed [RB-1:0] e_lr, e_rr;
      logic [TB-1:0] e_lt, e_rt;
      e_lr = -11'sd37; e_rr = 11'sd120; e_lt = 9'd45; e_rt = 9'd135;
      apply_reset();
      run = 1'b1; src_wr = 1'b1; pipe_full = 1'b0; acc = 0; c = 0;
      while (m_wait < 0 && c < 50) begin
         #1;
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++; $display("FAIL basic_load cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (pipe_wr_en_o) acc++;
         step(); c++;
      end
      tests++;
      if (acc != NP || src_full_o !== 1'b1) begin
         fails++; $display("FAIL basic_accepts got=%0d src_full=%b exp %0d 1", acc, src_full_o, NP);
      end
      d = $urandom_range(0, 20);
      for (int i = 0; i < d; i++) begin
         #1;
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++; $display("FAIL basic_wait cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
         end
         step();
      end
      hough_done = 1'b1; lrho_i = e_lr; rrho_i = e_rr; lth_i = e_lt; rth_i = e_rt;
      step();
      hough_done = 1'b0;
      rand_results();
      #1;
      tests++;
      if (result_valid_o !== 1'b1 || lrho_o !== e_lr || rrho_o !== e_rr || lth_o !== e_lt ||
          rth_o !== e_rt || frame_count_o !== 16'd1) begin
         fails++; $display("FAIL basic_result v=%b l=%0d/%0d r=%0d/%0d fc=%0d exp 1 -37/45 120/135 1",
                           result_valid_o, lrho_o, lth_o, rrho_o, rth_o, frame_count_o);
      end
      step();
      #1;
      tests++;
      if (frame_active_o !== 1'b1 || src_full_o !== 1'b0 || result_valid_o !== 1'b0 ||
          dut_vec() !== exp_vec()) begin
         fails++; $display("FAIL basic_reload got=%h exp=%h", dut_vec(), exp_vec());
      end
      step();
   endtask

   task automatic test_backpressure();
      int acc, c;
      apply_reset();
      run = 1'b1; acc = 0; c = 0;
      while (m_wait < 0 && c < 200) begin
         pipe_full = c[0];
         src_wr = ($urandom_range(0, 3) != 0);
         #1;
         tests++;
         if (dut_vec() !== exp_vec() || (pipe_wr_en_o && pipe_full)) begin
            fails++; $display("FAIL bp_load cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (pipe_wr_en_o) acc++;
         step(); c++;
      end
      pipe_full = 1'b0;
      tests++;
      if (acc != NP) begin
         fails++; $display("FAIL bp_accepts got=%0d exp=%0d", acc, NP);
      end
      hough_done = 1'b1; rand_results();
      step();
      hough_done = 1'b0;
      #1;
      tests++;
      if (result_valid_o !== 1'b1 || dut_vec() !== exp_vec()) begin
         fails++; $display("FAIL bp_result got=%h exp=%h", dut_vec(), exp_vec());
      end
      step();
   endtask

   task automatic test_run_drop();
      int acc, c;
      apply_reset();
      run = 1'b1; src_wr = 1'b1; acc = 0; c = 0;
      while (m_wait < 0 && c < 50) begin
         if (acc == 3) run = 1'b0;
         #1;
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++; $display("FAIL drop_load cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (pipe_wr_en_o) acc++;
         step(); c++;
      end
      tests++;
      if (acc != NP) begin
         fails++; $display("FAIL drop_accepts got=%0d exp=%0d", acc, NP);
      end
      step(); step();
      hough_done = 1'b1; rand_results();
      step();
      hough_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         tests++;
         if (src_full_o !== 1'b1 || frame_active_o !== 1'b0 || frame_count_o !== 16'd1 ||
             dut_vec() !== exp_vec()) begin
            fails++; $display("FAIL drop_idle cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
         end
         step();
      end
   endtask

   task automatic test_watchdog();
      int c, wstart, fstart, flushes;
      bit fin;
      logic [RB-1:0] s_lr;
      logic [TB-1:0] s_rt;
      apply_reset();
      run = 1'b1; src_wr = 1'b1; c = 0;
      while (m_wait < 0 && c < 50) begin
         step(); c++;
      end
      hough_done = 1'b1; rand_results();
      s_lr = lrho_i; s_rt = rth_i;
      step();
      hough_done = 1'b0;
      c = 0; wstart = -1; fstart = -1; flushes = 0; fin = 1'b0;
      while (!fin && c < 400) begin
         hough_done = m_loading ? 1'($urandom_range(0, 1)) : 1'b0;
         clear_err  = (m_wait == T - 1);
         if (m_flush > 0) run = 1'b0;
         #1;
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++; $display("FAIL wd_run cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (m_wait == 0 && wstart < 0) wstart = c;
         if (pipe_flush_o) begin
            if (fstart < 0) fstart = c;
            flushes++;
         end
         if (fstart >= 0 && !pipe_flush_o) fin = 1'b1;
         step(); c++;
      end
      hough_done = 1'b0; clear_err = 1'b0;
      tests++;
      if (fstart - wstart != T || flushes != F) begin
         fails++; $display("FAIL wd_flush_timing delay=%0d len=%0d exp %0d %0d",
                           fstart - wstart, flushes, T, F);
      end
      tests++;
      if (timeout_err_o !== 1'b1 || frame_count_o !== 16'd1 || lrho_o !== s_lr || rth_o !== s_rt) begin
         fails++; $display("FAIL wd_state err=%b fc=%0d lrho=%h rth=%h exp 1 1 %h %h",
                           timeout_err_o, frame_count_o, lrho_o, rth_o, s_lr, s_rt);
      end
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      #1;
      tests++;
      if (timeout_err_o !== 1'b0 || dut_vec() !== exp_vec()) begin
         fails++; $display("FAIL wd_clear err=%b exp 0", timeout_err_o);
      end
      step();
   endtask

   task automatic test_collision();
      int c, vseen;
      bit fseen;
      apply_reset();
      run = 1'b1; src_wr = 1'b1; c = 0;
      while (m_wait < 0 && c < 50) begin
         step(); c++;
      end
      vseen = 0; fseen = 1'b0;
      for (int i = 0; i < T + 4; i++) begin
         hough_done = (m_wait == T - 1);
         if (hough_done) begin rand_results(); run = 1'b0; end
         #1;
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++; $display("FAIL coll_run cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
         end
         if (pipe_flush_o) fseen = 1'b1;
         if (result_valid_o) vseen++;
         step();
      end
      hough_done = 1'b0;
      tests++;
      if (fseen || vseen != 1 || timeout_err_o !== 1'b0 || frame_count_o !== 16'd1) begin
         fails++; $display("FAIL coll_result flush=%b valids=%0d err=%b fc=%0d exp 0 1 0 1",
                           fseen, vseen, timeout_err_o, frame_count_o);
      end
   endtask

   task automatic test_back_to_back();
      int c, valids, dly;
      apply_reset();
      run = 1'b1; c = 0; valids = 0; dly = $urandom_range(0, 30);
      while (!(m_fc == 16'd3 && !m_done) && c < 1500) begin
         src_wr = ($urandom_range(0, 3) != 0);
         pipe_full = ($urandom_range(0, 2) == 0);
         if (m_wait >= 0) begin
            hough_done = (m_wait >= dly);
            if (hough_done) begin rand_results(); dly = $urandom_range(0, 30); end
         end else begin
            hough_done = ($urandom_range(0, 7) == 0);
         end
         #1;
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++; $display("FAIL b2b cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (result_valid_o) valids++;
         step(); c++;
      end
      hough_done = 1'b0; pipe_full = 1'b0;
      tests++;
      if (valids != 3 || frame_count_o !== 16'd3) begin
         fails++; $display("FAIL b2b_frames valids=%0d fc=%0d exp 3 3", valids, frame_count_o);
      end
   endtask

   task automatic test_reset_mid();
      int acc, c;
      apply_reset();
      run = 1'b1; src_wr = 1'b1; acc = 0; c = 0;
      while (acc < 5 && c < 50) begin
         #1;
         if (pipe_wr_en_o) acc++;
         step(); c++;
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      tests++;
      if (dut_vec() !== exp_vec() || src_full_o !== 1'b1 || pipe_wr_en_o !== 1'b0) begin
         fails++; $display("FAIL rstmid_values got=%h exp=%h", dut_vec(), exp_vec());
      end
      step(); step();
      rst_n = 1'b1; acc = 0; c = 0;
      while (m_wait < 0 && c < 50) begin
         #1;
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++; $display("FAIL rstmid_frame cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (pipe_wr_en_o) acc++;
         step(); c++;
      end
      tests++;
      if (acc != NP) begin
         fails++; $display("FAIL rstmid_accepts got=%0d exp=%0d", acc, NP);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_run_drop();
      test_watchdog();
      test_collision();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hough_frame_ctrl.md
# hough_frame_ctrl

Frame sequencer for the lane-detection pipeline. Gates the 24-bit pixel stream into the image FIFO so that exactly one WIDTH×HEIGHT frame enters per Hough pass, then holds off input until the Hough stage reports done. It latches the left/right lane results with a valid pulse and counts frames. A watchdog requests a pipeline flush if the Hough stage never completes. It sits between the camera/DDR pixel source and the image FIFO, and observes the Hough block's done/result outputs. The pixel data bus bypasses this block; only the handshake passes through it.

## Interface
- WIDTH, 512, frame width in pixels
- HEIGHT, 288, frame height in pixels
- RHO_BITS, 11, signed rho width
- THETA_BITS, 9, unsigned theta width
- TIMEOUT_CYCLES, 4000000, WAIT_HOUGH watchdog limit (≥2)
- FLUSH_CYCLES, 16, length of the pipe_flush assertion
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- run  in  1  level enable; frames start only while high
- clear_err  in  1  pulse; clears timeout_err
- src_wr_en  in  1  source pixel write request
- src_full  out  1  back-pressure to source
- pipe_wr_en  out  1  write enable to the image FIFO
- pipe_full  in  1  image FIFO full
- hough_done  in  1  Hough pass complete (pulse)
- left_rho_in, right_rho_in  in  RHO_BITS  signed lane rho from Hough
- left_theta_in, right_theta_in  in  THETA_BITS  lane theta from Hough
- left_rho_out, right_rho_out  out  RHO_BITS  latched results
- left_theta_out, right_theta_out  out  THETA_BITS  latched results
- result_valid  out  1  one-cycle pulse when results update
- frame_active  out  1  high in LOAD and WAIT_HOUGH
- frame_count  out  16  completed frames, wraps at 65535→0
- timeout_err  out  1  sticky watchdog error
- pipe_flush  out  1  flush request to the pipeline resets

## Operation
- Definitions:
  - accept = src_wr_en & pipe_wr_en.
  - pipe_wr_en = src_wr_en & !pipe_full & (state==LOAD). This path is combinational.
  - src_full = pipe_full | (state!=LOAD).
- States:
  - IDLE: moves to LOAD when run=1. Pixel counter and watchdog are cleared.
  - LOAD: counts accepted pixels, 0..WIDTH*HEIGHT-1. The accept at count WIDTH*HEIGHT-1 moves to WAIT_HOUGH. Deasserting run mid-frame does not abort; the frame completes.
  - WAIT_HOUGH: no pixels are accepted. The watchdog increments each cycle. hough_done=1 moves to DONE. If the watchdog reaches TIMEOUT_CYCLES-1 without hough_done, the FSM moves to FLUSH. If hough_done and the limit arrive in the same cycle, hough_done wins.
  - DONE (1 cycle): latches the four result inputs on entry (sampled the cycle hough_done=1). result_valid=1 and frame_count increments. Next state is LOAD if run=1, else IDLE.
  - FLUSH: pipe_flush=1 for FLUSH_CYCLES cycles. timeout_err is set on entry. Results and frame_count are unchanged. Next state is IDLE.
- Ignored and priority events:
  - hough_done outside WAIT_HOUGH is ignored.
  - clear_err clears timeout_err, except in the cycle FLUSH is entered, where setting has priority.
- Pixel counter and watchdog widths are $clog2 of their limits.

## Timing
- Reset values: src_full=1, pipe_wr_en=0, pipe_flush=0, result_valid=0, frame_active=0, timeout_err=0, frame_count=0, all rho/theta outputs=0. State is IDLE.
- src_full and pipe_wr_en respond combinationally to pipe_full and src_wr_en in the same cycle. The state-dependent term is registered.
- IDLE→LOAD takes 1 cycle after run is sampled high. src_full falls in the cycle after run rises.
- src_full rises in the cycle after the last accept.
- Latency from hough_done to result_valid and the outputs updating is 1 cycle. result_valid is registered, high exactly 1 cycle.
- Back-to-back frames: the next LOAD begins 2 cycles after hough_done.
- pipe_flush timing: it rises TIMEOUT_CYCLES cycles after WAIT_HOUGH entry and stays high exactly FLUSH_CYCLES cycles.
- Asserting reset mid-frame asynchronously forces all reset values. Pixels already written to the FIFO are not tracked.

## Test plan
The bench uses WIDTH=4, HEIGHT=2, TIMEOUT_CYCLES=100, FLUSH_CYCLES=4.

- **Basic frame:** run=1, pipe_full=0, src_wr_en held high.
  - Exactly 8 pipe_wr_en pulses occur, then src_full=1.
  - Assert hough_done with rho=-37, theta=45 / rho=120, theta=135.
  - Required: result_valid one cycle later, outputs match, frame_count=1, LOAD re-entered 2 cycles after hough_done.
- **Back-pressure:** toggle pipe_full every other cycle during LOAD.
  - Required: pipe_wr_en never high while pipe_full=1, still exactly 8 accepts.
- **run drop mid-frame:** deassert run after 3 accepts.
  - Required: 5 more accepts, then after hough_done go to IDLE (src_full stays 1), frame_count=1.
- **Watchdog:** no hough_done.
  - Required: pipe_flush high for 4 cycles starting 100 cycles after WAIT_HOUGH entry, timeout_err=1, frame_count unchanged, results unchanged.
  - Then pulse clear_err → timeout_err=0.
- **Done/timeout collision:** hough_done on the final watchdog cycle.
  - Required: DONE taken, no pipe_flush, timeout_err=0.
- **Reset mid-frame:** reset low after 5 accepts, then high.
  - Required: all outputs at reset values.
  - With run=1, a fresh frame of exactly 8 accepts follows.
